sha_mem_arbiter: RTL and testbench
==================================

Name: sha_mem_arbiter

Overview:
Round-robin arbiter that shares the single 16-bit-address / 32-bit-data word memory port between NUM_CORES SHA-256 hashing cores. Each core requests the port, holds it for a burst (block fetch or hash write-back), and gets its read data back tagged with a per-core valid. The arbiter sits between the core array and the message/output memory and drives mem_clk, mem_we, mem_addr and mem_write_data.

Parameters:
NUM_CORES, 4, number of requesting cores (2..16)
MAX_BURST, 16, maximum consecutive granted cycles while another core is waiting (1..255)

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
req  in  NUM_CORES  per-core port request; held high for the whole burst
we  in  NUM_CORES  per-core write enable, qualified by req and gnt
addr  in  NUM_CORES*16  per-core word address; core i uses bits [16i+15:16i]
wdata  in  NUM_CORES*32  per-core write data; core i uses bits [32i+31:32i]
gnt  out  NUM_CORES  one-hot grant, registered
rdata  out  32  read data, broadcast to all cores (equals mem_read_data)
rvalid  out  NUM_CORES  one-hot pulse: rdata belongs to core i this cycle
mem_clk  out  1  equals clk
mem_we  out  1  memory write enable
mem_addr  out  16  memory word address
mem_write_data  out  32  memory write data
mem_read_data  in  32  memory read data, valid one cycle after the address

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: gnt=0, rvalid=0, mem_we=0, mem_addr=0, burst counter=0. The round-robin pointer resets so that core 0 has the highest priority.
- States:
  - IDLE (no grant).
  - OWN(k) (gnt[k]=1).
- IDLE:
  - If any req is high in cycle t, gnt[winner]=1 in cycle t+1.
  - The winner is the first requester at or after the pointer, searching cyclically.
- Access cycle: a cycle with gnt[k]=1 and req[k]=1.
  - mem_addr, mem_we and mem_write_data come combinationally from core k.
  - In any other cycle, mem_we=0 and mem_addr holds its last value.
- Read return:
  - A read access (we[k]=0) in cycle t gives rvalid[k]=1 in cycle t+1.
  - In that cycle, rdata = mem_read_data.
  - This holds even if the grant has moved in the meantime.
- Release: if req[k]=0 while gnt[k]=1, then in the next cycle:
  - gnt moves to the next requester after k (cyclic), or the arbiter returns to IDLE.
  - The release cycle itself performs no access (one bubble).
- Burst limit:
  - The counter increments on each access cycle of the current owner.
  - When it reaches MAX_BURST and any other req is high, gnt moves to the next requester in the following cycle, even if req[k] is still high.
  - A preempted core keeps req high and is re-granted on its next turn.
  - If no other core is requesting, the owner keeps the grant and the counter restarts at 0.
- Pointer: updated to owner+1 (mod NUM_CORES) whenever a grant is issued. This is strict round-robin, so no core can starve another.
- Simultaneous events: preemption and release in the same cycle are treated as a release. New requests arriving in a handover cycle take part in selecting the next owner.
- Cores may not change we/addr/wdata expecting them to take effect without gnt. Accesses without a grant are ignored.
- Reset mid-burst:
  - gnt and rvalid drop in the next cycle.
  - A pending read return is discarded (no rvalid).
  - Memory writes already issued are not undone.

Decomposition:
- Shared package sha_pkg holds:
  - ADDR_W=16 and DATA_W=32.
  - the state enum {ARB_IDLE, ARB_OWN}.
  - the function rr_pick(req, ptr), which returns a one-hot winner.
- One sub-module, rr_priority_pick, is natural: a combinational cyclic priority encoder. It is reused later by the job dispatcher.

Test Plan:
1. Reset with req=4'b1111 held -> gnt=0 during reset. First cycle after reset: gnt=4'b0000. Next cycle: gnt=4'b0001.
2. Core 2 alone reads addr 0x0010..0x001F (16 reads) -> gnt=4'b0100 one cycle after req. mem_addr follows 0x0010+n. rvalid[2] pulses 16 times, each one cycle after its address, and rdata matches the memory model.
3. Cores 0 and 1 request continuously, MAX_BURST=16 -> grants alternate 0,1,0,… with exactly 16 access cycles each and one bubble at each handover.
4. Core 3 writes 8 words (0xDEADBEEF+n) to 0x0100 while cores 0 and 1 request -> the memory model holds all 8 words. Core 3 is not preempted (8 < 16). Next grant goes to core 0.
5. Core 1 issues a read at 0x0040, then releases, and core 2 is granted -> rvalid[1] fires on the handover cycle with the data from 0x0040. rvalid[2] stays low.
6. Reset asserted mid-burst with a read outstanding -> no rvalid. gnt=0 and mem_we=0 in the next cycle. After reset, core 0 again has the highest priority.

Source files
------------

// File: rtl/sha_pkg.sv
// sha_pkg: shared widths, arbiter state encoding and the cyclic round-robin pick
// used by the memory arbiter and the job dispatcher.
package sha_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int MAX_CORES = 16;

   typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_e;

   // One-hot winner: first set bit of req at or after ptr, wrapping modulo n.
   function automatic logic [MAX_CORES-1:0] rr_pick(input logic [MAX_CORES-1:0] req,
                                                    input logic [3:0] ptr, input int n);
      logic [MAX_CORES-1:0] w;
      logic [3:0] idx;
      w = '0;
      for (int i = MAX_CORES-1; i >= 0; i--) begin
         if (i < n) begin
            idx = 4'((int'(ptr) + i) % n);
            if (req[idx]) begin
               w = '0;
               w[idx] = 1'b1;
            end
         end
      end
      return w;
   endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational cyclic priority encoder returning a one-hot
// winner, searching from ptr_i upwards and wrapping.
module rr_priority_pick import sha_pkg::*; #(
   parameter int N = 4
) (
   input  logic [N-1:0]                      req_i,
   input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
   output logic [N-1:0]                      gnt_o
);
   assign gnt_o = N'(rr_pick(MAX_CORES'(req_i), 4'(ptr_i), N));
endmodule

// File: rtl/sha_mem_arbiter.sv
// sha_mem_arbiter: round-robin sharing of one 16-bit-address / 32-bit-data
// memory port among NUM_CORES SHA-256 cores, with burst limit and tagged reads.
module sha_mem_arbiter import sha_pkg::*; #(
   parameter int NUM_CORES = 4,
   parameter int MAX_BURST = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CORES-1:0]        req,
   input  logic [NUM_CORES-1:0]        we,
   input  logic [NUM_CORES*ADDR_W-1:0] addr,
   input  logic [NUM_CORES*DATA_W-1:0] wdata,
   output logic [NUM_CORES-1:0]        gnt,
   output logic [DATA_W-1:0]           rdata,
   output logic [NUM_CORES-1:0]        rvalid,
   output logic                        mem_clk,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_write_data,
   input  logic [DATA_W-1:0]           mem_read_data
);
   localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   arb_state_e           state_q, state_d;
   logic [PW-1:0]        own_q, own_d, ptr_q, ptr_d, win_idx;
   logic [7:0]           cnt_q, cnt_d;
   logic [NUM_CORES-1:0] gnt_q, gnt_d, rv_q, rv_d, win;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic                 own_req, others, preempt, acc;

   rr_priority_pick #(.N(NUM_CORES)) u_pick (
      .req_i(req),
      .ptr_i(ptr_q),
      .gnt_o(win)
   );

   assign own_req = req[own_q];
   assign others  = |(req & ~gnt_q);
   // The cycle the burst limit is hit with someone waiting is the handover bubble.
   assign preempt = (state_q == ARB_OWN) && own_req && others && (cnt_q == 8'(MAX_BURST));
   assign acc     = (state_q == ARB_OWN) && own_req && !preempt;
   assign mem_clk = clk;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         own_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         rv_q    <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         rv_q    <= rv_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_CORES; i++) if (win[i]) win_idx = PW'(i);
      state_d = acc ? state_q : ((|req) ? ARB_OWN : ARB_IDLE);
      gnt_d   = acc ? gnt_q : win;
      own_d   = acc ? own_q : win_idx;
      ptr_d   = (acc || !(|req)) ? ptr_q : ((win_idx == PW'(NUM_CORES-1)) ? '0 : win_idx + 1'b1);
      cnt_d   = !acc ? '0 : ((cnt_q == 8'(MAX_BURST)) ? 8'd1 : cnt_q + 8'd1);
      rv_d    = '0;
      rv_d[own_q] = acc && !we[own_q];
      addr_d  = mem_addr;
   end

   always_comb begin
      gnt            = gnt_q;
      rvalid         = rv_q;
      rdata          = mem_read_data;
      mem_we         = acc && we[own_q];
      mem_addr       = acc ? addr[own_q*ADDR_W +: ADDR_W] : addr_q;
      mem_write_data = wdata[own_q*DATA_W +: DATA_W];
   end
endmodule

// File: tb/tb_sha_mem_arbiter.sv
// tb_sha_mem_arbiter: directed scenarios for the SHA memory-port arbiter
// against a registered-read memory model with a write log.
module tb_sha_mem_arbiter;
   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req, we;
   logic [63:0]  addr;
   logic [127:0] wdata;
   logic [3:0]   gnt, rvalid;
   logic [31:0]  rdata, mem_write_data, mem_read_data;
   logic         mem_clk, mem_we;
   logic [15:0]  mem_addr;
   logic [31:0]  wlog [0:65535];
   int           n_chk = 0;
   int           n_fail = 0;

   sha_mem_arbiter #(.NUM_CORES(4), .MAX_BURST(16)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .mem_clk(mem_clk), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [15:0] a);
      return {a ^ 16'hC0DE, ~a};
   endfunction

   always @(posedge clk) begin
      mem_read_data <= pat(mem_addr);
      if (mem_we) wlog[mem_addr] <= mem_write_data;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #2;
   endtask

   task automatic idle_inputs;
      req = '0; we = '0; addr = '0; wdata = '0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      idle_inputs();
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle_inputs();
      req = 4'b1111;
      tick(); tick(); settle();
      n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt_during: gnt=%b expected=0000", gnt); end
      n_chk++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL rst_rvalid: rvalid=%b expected=0000", rvalid); end
      n_chk++; if (mem_clk !== 1'b1) begin n_fail++; $display("FAIL rst_mem_clk: mem_clk=%b expected=1", mem_clk); end
      tick();
      reset = 1'b0;
      settle();
      n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt_first: gnt=%b expected=0000", gnt); end
      n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: mem_we=%b expected=0", mem_we); end
      n_chk++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_addr: mem_addr=%h expected=0000", mem_addr); end
      tick(); settle();
      n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rst_gnt_next: gnt=%b expected=0001", gnt); end
      idle_inputs();
   endtask

   task automatic test_single_read;
      int pulses = 0;
      do_reset();
      req = 4'b0100;
      addr[47:32] = 16'h0010;
      settle();
      n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rd_gnt_req_cycle: gnt=%b expected=0000", gnt); end
      tick();
      for (int n = 0; n < 16; n++) begin
         addr[47:32] = 16'h0010 + 16'(n);
         settle();
         n_chk++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL rd_gnt n=%0d: gnt=%b expected=0100", n, gnt); end
         n_chk++; if (mem_addr !== 16'h0010 + 16'(n)) begin n_fail++; $display("FAIL rd_addr n=%0d: mem_addr=%h expected=%h", n, mem_addr, 16'h0010 + 16'(n)); end
         n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_we n=%0d: mem_we=%b expected=0", n, mem_we); end
         if (n == 0) begin
            n_chk++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL rd_rvalid_first: rvalid=%b expected=0000", rvalid); end
         end else begin
            n_chk++; if (rvalid !== 4'b0100) begin n_fail++; $display("FAIL rd_rvalid n=%0d: rvalid=%b expected=0100", n, rvalid); end
            n_chk++; if (rdata !== pat(16'h000F + 16'(n))) begin n_fail++; $display("FAIL rd_rdata n=%0d: rdata=%h expected=%h", n, rdata, pat(16'h000F + 16'(n))); end
         end
         if (rvalid[2]) pulses++;
         tick();
      end
      req = 4'b0000;
      settle();
      n_chk++; if (rvalid !== 4'b0100) begin n_fail++; $display("FAIL rd_rvalid_last: rvalid=%b expected=0100", rvalid); end
      n_chk++; if (rdata !== pat(16'h001F)) begin n_fail++; $display("FAIL rd_rdata_last: rdata=%h expected=%h", rdata, pat(16'h001F)); end
      if (rvalid[2]) pulses++;
      tick(); settle();
      n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rd_gnt_idle: gnt=%b expected=0000", gnt); end
      n_chk++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL rd_rvalid_idle: rvalid=%b expected=0000", rvalid); end
      n_chk++; if (pulses != 16) begin n_fail++; $display("FAIL rd_pulse_count: pulses=%0d expected=16", pulses); end
      idle_inputs();
   endtask

   task automatic test_burst_alternate;
      logic [3:0] eg, er;
      do_reset();
      req = 4'b0011;
      addr[15:0] = 16'h0200;
      addr[31:16] = 16'h0300;
      for (int c = 0; c < 70; c++) begin
         settle();
         eg = (c == 0) ? 4'b0000 : 4'(1 << (((c - 1) / 17) % 2));
         er = (c >= 2 && ((c - 2) % 17) != 16) ? 4'(1 << (((c - 2) / 17) % 2)) : 4'b0000;
         n_chk++; if (gnt !== eg) begin n_fail++; $display("FAIL burst_gnt c=%0d: gnt=%b expected=%b", c, gnt, eg); end
         n_chk++; if (rvalid !== er) begin n_fail++; $display("FAIL burst_rvalid c=%0d: rvalid=%b expected=%b", c, rvalid, er); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_write_burst;
      do_reset();
      req = 4'b1000;
      we = 4'b1000;
      addr[63:48] = 16'h0100;
      wdata[127:96] = 32'hDEADBEEF;
      settle();
      n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL wr_gnt_req_cycle: gnt=%b expected=0000", gnt); end
      tick();
      req = 4'b1011;
      for (int n = 0; n < 8; n++) begin
         addr[63:48] = 16'h0100 + 16'(n);
         wdata[127:96] = 32'hDEADBEEF + 32'(n);
         settle();
         n_chk++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wr_gnt n=%0d: gnt=%b expected=1000", n, gnt); end
         n_chk++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_we n=%0d: mem_we=%b expected=1", n, mem_we); end
         n_chk++; if (mem_addr !== 16'h0100 + 16'(n)) begin n_fail++; $display("FAIL wr_addr n=%0d: mem_addr=%h expected=%h", n, mem_addr, 16'h0100 + 16'(n)); end
         n_chk++; if (mem_write_data !== 32'hDEADBEEF + 32'(n)) begin n_fail++; $display("FAIL wr_data n=%0d: data=%h expected=%h", n, mem_write_data, 32'hDEADBEEF + 32'(n)); end
         tick();
      end
      req = 4'b0011;
      we = 4'b0000;
      settle();
      n_chk++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wr_gnt_release: gnt=%b expected=1000", gnt); end
      n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_we_release: mem_we=%b expected=0", mem_we); end
      n_chk++; if (mem_addr !== 16'h0107) begin n_fail++; $display("FAIL wr_addr_hold: mem_addr=%h expected=0107", mem_addr); end
      tick(); settle();
      n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wr_next_gnt: gnt=%b expected=0001", gnt); end
      for (int n = 0; n < 8; n++) begin
         n_chk++; if (wlog[16'h0100 + 16'(n)] !== 32'hDEADBEEF + 32'(n)) begin n_fail++; $display("FAIL wr_mem n=%0d: mem=%h expected=%h", n, wlog[16'h0100 + 16'(n)], 32'hDEADBEEF + 32'(n)); end
      end
      idle_inputs();
   endtask

   task automatic test_read_handover;
      do_reset();
      req = 4'b0010;
      addr[31:16] = 16'h0040;
      settle();
      n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL ho_gnt_req_cycle: gnt=%b expected=0000", gnt); end
      tick();
      req = 4'b0110;
      we = 4'b0100;
      addr[47:32] = 16'h0080;
      wdata[95:64] = 32'h12345678;
      settle();
      n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL ho_gnt_core1: gnt=%b expected=0010", gnt); end
      n_chk++; if (mem_addr !== 16'h0040) begin n_fail++; $display("FAIL ho_addr: mem_addr=%h expected=0040", mem_addr); end
      n_chk++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL ho_rvalid_access: rvalid=%b expected=0000", rvalid); end
      tick();
      req = 4'b0100;
      settle();
      n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL ho_gnt_release: gnt=%b expected=0010", gnt); end
      n_chk++; if (rvalid !== 4'b0010) begin n_fail++; $display("FAIL ho_rvalid: rvalid=%b expected=0010", rvalid); end
      n_chk++; if (rdata !== pat(16'h0040)) begin n_fail++; $display("FAIL ho_rdata: rdata=%h expected=%h", rdata, pat(16'h0040)); end
      n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL ho_we_bubble: mem_we=%b expected=0", mem_we); end
      tick(); settle();
      n_chk++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL ho_gnt_core2: gnt=%b expected=0100", gnt); end
      n_chk++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL ho_rvalid_core2: rvalid=%b expected=0000", rvalid); end
      n_chk++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL ho_we_core2: mem_we=%b expected=1", mem_we); end
      n_chk++; if (mem_addr !== 16'h0080) begin n_fail++; $display("FAIL ho_addr_core2: mem_addr=%h expected=0080", mem_addr); end
      tick();
      req = 4'b0000;
      settle();
      n_chk++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL ho_rvalid_after: rvalid=%b expected=0000", rvalid); end
      idle_inputs();
   endtask

   task automatic test_reset_midburst;
      do_reset();
      req = 4'b0001;
      addr[15:0] = 16'h0020;
      tick(); settle();
      n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_gnt: gnt=%b expected=0001", gnt); end
      tick();
      addr[15:0] = 16'h0021;
      reset = 1'b1;
      req = 4'b1111;
      settle();
      n_chk++; if (rvalid !== 4'b0001) begin n_fail++; $display("FAIL mid_rvalid_prev: rvalid=%b expected=0001", rvalid); end
      n_chk++; if (rdata !== pat(16'h0020)) begin n_fail++; $display("FAIL mid_rdata_prev: rdata=%h expected=%h", rdata, pat(16'h0020)); end
      tick(); settle();
      n_chk++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL mid_rvalid_discard: rvalid=%b expected=0000", rvalid); end
      n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_gnt_drop: gnt=%b expected=0000", gnt); end
      n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_we: mem_we=%b expected=0", mem_we); end
      tick();
      reset = 1'b0;
      settle();
      n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_gnt_first: gnt=%b expected=0000", gnt); end
      n_chk++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL mid_rvalid_first: rvalid=%b expected=0000", rvalid); end
      tick(); settle();
      n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_priority: gnt=%b expected=0001", gnt); end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_single_read();
      test_burst_alternate();
      test_write_burst();
      test_read_handover();
      test_reset_midburst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
